// File: rtl/ram_share_arb.sv
// ram_share_arb: two-requester arbiter in front of one single-port,
// byte-enable, 32-bit RAM with a 1-cycle registered read. Port B
// (streaming engine) wins contention. Port A (CPU bus) is guaranteed a
// grant once it has lost MAX_WAIT consecutive contended cycles. A
// saturating counter of contended cycles is exported for software.
module ram_share_arb #(
  parameter int LOGSIZE  = 16,
  parameter int MAX_WAIT = 7,
  localparam int AW      = LOGSIZE - 2
) (
  input  logic          bus_clk,
  input  logic          bus_reset_l,
  // port A (CPU bus slave path)
  input  logic          a_req,
  input  logic [3:0]    a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wr_data,
  output logic          a_ack,
  output logic          a_rd_valid,
  output logic [31:0]   a_rd_data,
  // port B (real-time streaming engine)
  input  logic          b_req,
  input  logic [3:0]    b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wr_data,
  output logic          b_ack,
  output logic          b_rd_valid,
  output logic [31:0]   b_rd_data,
  // RAM side
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wr_data,
  input  logic [31:0]   ram_rd_data,
  // contention statistics
  input  logic          conflict_clr,
  output logic [15:0]   conflict_cnt
);

  localparam logic [7:0] MAX_WAIT_V = 8'(MAX_WAIT);

  logic       grant_a;
  logic       grant_b;
  logic       contend;
  logic [7:0] wait_cnt;
  logic       a_rd_own;
  logic       b_rd_own;

  assign contend = a_req & b_req;

  // Arbitration: B wins contention until A has waited long enough;
  // nothing is granted while reset is held.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (bus_reset_l) begin
      if (a_req && (!b_req || (wait_cnt >= MAX_WAIT_V))) begin
        grant_a = 1'b1;
      end else if (b_req) begin
        grant_b = 1'b1;
      end
    end
  end

  // RAM request mux: granted port drives the RAM; idle defaults to A fields with no write.
  always_comb begin
    ram_we      = 4'h0;
    ram_addr    = a_addr;
    ram_wr_data = a_wr_data;
    if (grant_a) begin
      ram_we = a_we;
    end else if (grant_b) begin
      ram_we      = b_we;
      ram_addr    = b_addr;
      ram_wr_data = b_wr_data;
    end
  end

  assign a_ack = grant_a;
  assign b_ack = grant_b;

  // Read-owner flags: remember which port issued the read whose data returns next cycle.
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      a_rd_own <= 1'b0;
      b_rd_own <= 1'b0;
    end else begin
      a_rd_own <= grant_a && (a_we == 4'h0);
      b_rd_own <= grant_b && (b_we == 4'h0);
    end
  end

  // Read return: data is gated to zero when not owned so both ports can be OR-combined.
  always_comb begin
    a_rd_valid = a_rd_own;
    b_rd_valid = b_rd_own;
    a_rd_data  = a_rd_own ? ram_rd_data : 32'h0;
    b_rd_data  = b_rd_own ? ram_rd_data : 32'h0;
  end

  // Starvation counter: counts cycles A is pending while B holds the RAM.
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      wait_cnt <= 8'h0;
    end else if (grant_a) begin
      wait_cnt <= 8'h0;
    end else if (a_req && grant_b && (wait_cnt != 8'hFF)) begin
      wait_cnt <= wait_cnt + 8'h1;
    end
  end

  // Contention statistics: saturating count, clear has priority over increment.
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      conflict_cnt <= 16'h0;
    end else if (conflict_clr) begin
      conflict_cnt <= 16'h0;
    end else if (contend && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'h1;
    end
  end

endmodule

// File: doc/ram_share_arb.md
# ram_share_arb

Shares one single-port byte-enable RAM (32-bit word, 1-cycle registered read) between two requesters. Port A is the CPU-side bus slave path; port B is a real-time streaming engine such as a capture writer or playback reader. Port B has priority, and a starvation counter guarantees port A forward progress. The block sits between the bus decode logic and the RAM instance and also counts contention cycles for software visibility.

## Interface
- `LOGSIZE`, default 16: log2 of RAM size in bytes. The word address width is `AW = LOGSIZE-2`.
- `MAX_WAIT`, default 7: number of consecutive contended cycles port A may lose before it is guaranteed the next grant. Range 0..255.
- `bus_clk`  in  1: the only clock.
- `bus_reset_l`  in  1: asynchronous, active-low reset.
- `a_req`  in  1: port A request. Held high with the fields below stable until `a_ack`.
- `a_we`  in  4: port A byte write enables. All-zero means a read.
- `a_addr`  in  AW: port A word address.
- `a_wr_data`  in  32: port A write data.
- `a_ack`  out  1: port A access accepted this cycle.
- `a_rd_valid`  out  1: port A read data valid.
- `a_rd_data`  out  32: port A read data. Zero whenever `a_rd_valid` is low.
- `b_req`, `b_we`, `b_addr`, `b_wr_data`, `b_ack`, `b_rd_valid`, `b_rd_data`: port B, with the same widths and meanings as port A.
- `ram_we`  out  4: RAM byte write enables.
- `ram_addr`  out  AW: RAM word address.
- `ram_wr_data`  out  32: RAM write data.
- `ram_rd_data`  in  32: RAM read data. Valid on the cycle after the address is presented.
- `conflict_clr`  in  1: synchronous clear of `conflict_cnt`.
- `conflict_cnt`  out  16: saturating count of contended cycles.

## Operation
- **Grant (combinational, evaluated every cycle):**
  - Only A requests: grant A.
  - Only B requests: grant B.
  - Both request: grant A if `wait_cnt >= MAX_WAIT`, otherwise grant B.
  - Neither requests: no grant.
- **Granted port:**
  - Its `*_ack` is high this cycle.
  - Its `we`, `addr` and `wr_data` are muxed onto the `ram_*` outputs.
- **No grant:** `ram_we = 0`, `ram_addr` and `ram_wr_data` = port A fields (don't-care, but deterministic).
- **Read tracking:**
  - A granted read (`we == 0`) sets a registered owner flag for the next cycle.
  - That flag drives exactly one of `a_rd_valid` / `b_rd_valid`.
  - Data is `ram_rd_data` when valid, zero otherwise, so outputs can be OR-combined onto the bus.
- **Writes** produce no `rd_valid`.
- **`wait_cnt`** (8-bit register):
  - Increments, saturating at 255, on each cycle A requests and B is granted.
  - Clears on any A grant.
  - Holds otherwise.
- **`conflict_cnt`:**
  - +1 on each cycle where `a_req && b_req`, saturating at 0xFFFF.
  - `conflict_clr` loads 0 and takes precedence over a simultaneous increment.
- **Protocol:**
  - A requester may keep `req` high after `ack` to issue a new access the very next cycle. Back-to-back throughput is 1 access per cycle per port when uncontended.
  - Dropping `req` before `ack` is illegal. A bench assertion covers this rule.

## Timing
- **Reset (asynchronous assert, synchronous deassert by system):**
  - `wait_cnt` = 0, `conflict_cnt` = 0, read-owner flags = 0.
  - `a_rd_valid` = `b_rd_valid` = 0, rd_data = 0.
  - While `bus_reset_l` is low, `a_ack` = `b_ack` = 0 and `ram_we` = 0, regardless of requests.
- **Ack latency:** 0 cycles from `req` when granted. The RAM write occurs at the end of the ack cycle.
- **Read latency:** ack in cycle N; `*_rd_valid` and data in cycle N+1 for exactly one cycle.
- **Write then read of the same word by the same port:** write ack at N, read ack at N+1, new data at N+2.
- **Contention worst case for A** with B requesting continuously: A is acked no later than `MAX_WAIT`+1 cycles after first request. With `MAX_WAIT` = 0, A always wins contention.
- **Reset mid-read:** a read acked in cycle N followed by reset assertion produces no `rd_valid` after reset.

## Test plan
- **Uncontended:** A writes 0xDEADBEEF with `we` = 0xF to word 5, then reads word 5 → `a_ack` each cycle; `a_rd_valid` at read+1 with 0xDEADBEEF; `b_rd_valid` stays 0.
- **Byte enables:** A writes 0x11223344 with `we` = 0x4 over 0 → read returns 0x00220000.
- **Priority and starvation:** `MAX_WAIT` = 3, B requests every cycle and A requests from cycle 0 → B acked cycles 0–2, A acked cycle 3, B cycle 4; `wait_cnt` = 0 after cycle 3; `conflict_cnt` counts 4 over cycles 0–3.
- **Read routing:** A read at word 1 (holding 0xA) and B read at word 2 (holding 0xB) interleaved → `a_rd_data` = 0xA only with `a_rd_valid`, `b_rd_data` = 0xB only with `b_rd_valid`, the other port reads 0.
- **Saturation and clear:** force 70000 contended cycles → `conflict_cnt` = 0xFFFF; `conflict_clr` coincident with contention → 0 next cycle.
- **Asynchronous reset mid-stream:** assert `bus_reset_l` low between edges during an acked read → outputs go to reset values immediately; no acks while low; normal operation after release.
